fetch_unit: RTL

- Instruction fetch stage directly upstream of decode and the immediate generator.
- Owns the PC and issues word requests to instruction memory over a valid/ready handshake, at most one request outstanding.
- Buffers returned instructions with their PC in a 2-entry FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word requests to
// instruction memory and buffers returned instructions in a 2-entry FIFO for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             outstanding_q, outstanding_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             req_epoch_q, req_epoch_d;
  logic             epoch_q, epoch_d;
  entry_t           fifo_q [DEPTH];
  entry_t           fifo_d [DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic req_fire;
  logic rsp_accept;
  logic push;
  logic pop;
  entry_t head;

  // Request credit: one outstanding, room in the FIFO, never while redirecting.
  always_comb begin
    imem_req_valid = rst_n && !outstanding_q && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_accept     = imem_rsp_valid && outstanding_q;
    push           = rsp_accept && (req_epoch_q == epoch_q) && !redirect_valid;
    pop            = (count_q != '0) && id_ready && !redirect_valid;
  end

  // Decode-facing view of the FIFO head; NOP when empty.
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    if_valid = (count_q != '0);
    if_instr = if_valid ? head.instr : NOP_INSTR;
    if_pc    = if_valid ? head.pc : '0;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    req_pc_d      = req_pc_q;
    req_epoch_d   = req_epoch_q;
    epoch_d       = epoch_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (req_fire) begin
      pc_d          = pc_q + XLEN'(4);
      outstanding_d = 1'b1;
      req_pc_d      = pc_q;
      req_epoch_d   = epoch_q;
    end

    if (rsp_accept) begin
      outstanding_d = 1'b0;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{instr: imem_rsp_data, pc: req_pc_q};
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect wins: flush, retarget, and mark any in-flight request stale.
    // Epoch is forced opposite to the request's so repeated redirects cannot re-validate it.
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      if (outstanding_q && !imem_rsp_valid) begin
        epoch_d = ~req_epoch_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      req_pc_q      <= RESET_PC;
      req_epoch_q   <= 1'b0;
      epoch_q       <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '{instr: NOP_INSTR, pc: '0};
      end
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      req_pc_q      <= req_pc_d;
      req_epoch_q   <= req_epoch_d;
      epoch_q       <= epoch_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule
